// File: rtl/instruction_fifo_if.sv
// Host/control-unit handshake bundle for instruction_fifo.
// master: host PIO plus controlUnit side; slave: the FIFO itself.
interface instruction_fifo_if #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
);
    logic          wrreg;
    logic [31:0]   dataA;
    logic [31:0]   dataB;
    logic          rdreg;
    logic          clr_overflow;
    logic [31:0]   dataA_out;
    logic [31:0]   dataB_out;
    logic [3:0]    opCode;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   used_words;
    logic          overflow;

    modport master (
        output wrreg, dataA, dataB, rdreg, clr_overflow,
        input  dataA_out, dataB_out, opCode, fifo_empty, fifo_full,
               used_words, overflow
    );

    modport slave (
        input  wrreg, dataA, dataB, rdreg, clr_overflow,
        output dataA_out, dataB_out, opCode, fifo_empty, fifo_full,
               used_words, overflow
    );
endinterface

// File: rtl/instruction_fifo.sv
// Host-side first-word-fall-through instruction FIFO feeding controlUnit.
// Pushes on the rising edge of the level-held wrreg strobe; pops on rdreg.
// Optional feature macro: INSTR_FIFO_OVERFLOW_EN enables the sticky
// overflow flag for writes dropped while full (tied to 0 otherwise).
module instruction_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    instruction_fifo_if.slave bus
);

    logic [63:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_used;
    logic          r_wr_prev;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [63:0]   w_head;

    assign w_empty    = (r_used == '0);
    assign w_full     = (r_used == (AW+1)'(DEPTH));
    assign w_push_req = bus.wrreg & ~r_wr_prev;
    assign w_pop      = bus.rdreg & ~w_empty;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // Strobe history for rising-edge detection; held high through reset
    // so a strobe already asserted at release does not write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_prev <= 1'b1;
        end else begin
            r_wr_prev <= bus.wrreg;
        end
    end

    // Entry storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {bus.dataA, bus.dataB};
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_used <= r_used + (AW+1)'(1);
                2'b01:   r_used <= r_used - (AW+1)'(1);
                default: r_used <= r_used;
            endcase
        end
    end

`ifdef INSTR_FIFO_OVERFLOW_EN
    // Sticky dropped-write flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end
`else
    logic w_unused_ovf;
    assign w_unused_ovf = bus.clr_overflow | w_drop;
    assign r_overflow   = 1'b0;
`endif

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign bus.dataA_out  = w_head[63:32];
    assign bus.dataB_out  = w_head[31:0];
    assign bus.opCode     = w_head[35:32];
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.used_words = r_used;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_instruction_fifo.sv
// Self-checking bench for instruction_fifo: queue-based reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_instruction_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk;
    logic reset;

    instruction_fifo_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    instruction_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] m_q[$];
    bit          m_prev = 1'b1;
    bit          m_ovf  = 1'b0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs present at each rising edge.
    always @(posedge clk) begin
        bit push_req, pop, drop;
        if (reset) begin
            m_q.delete();
            m_prev = 1'b1;
            m_ovf  = 1'b0;
        end else begin
            push_req = bus.wrreg && !m_prev;
            pop      = bus.rdreg && (m_q.size() > 0);
            drop     = push_req && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push_req && !drop) m_q.push_back({bus.dataA, bus.dataB});
`ifdef INSTR_FIFO_OVERFLOW_EN
            if (drop) m_ovf = 1'b1;
            else if (bus.clr_overflow) m_ovf = 1'b0;
`endif
            m_prev = bus.wrreg;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [63:0] head;
        if (chk_en) begin
            head = (m_q.size() == 0) ? 64'd0 : m_q[0];
            chk("empty",  64'(bus.fifo_empty), 64'(m_q.size() == 0));
            chk("full",   64'(bus.fifo_full),  64'(m_q.size() == DEPTH));
            chk("used",   64'(bus.used_words), 64'(m_q.size()));
            chk("dataA",  64'(bus.dataA_out),  64'(head[63:32]));
            chk("dataB",  64'(bus.dataB_out),  64'(head[31:0]));
            chk("opCode", 64'(bus.opCode),     64'(head[35:32]));
            chk("ovf",    64'(bus.overflow),   64'(m_ovf));
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wrreg = 1'b0; bus.rdreg = 1'b0; bus.clr_overflow = 1'b0;
    endtask

    // One write: strobe high for a cycle then low for a cycle.
    task automatic wr(input logic [31:0] a, input logic [31:0] b, input bit rd);
        bus.dataA = a; bus.dataB = b; bus.wrreg = 1'b1; bus.rdreg = rd;
        cycle();
        bus.wrreg = 1'b0; bus.rdreg = 1'b0;
        cycle();
    endtask

    task automatic pop1();
        bus.rdreg = 1'b1;
        cycle();
        bus.rdreg = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.wrreg = 1'b1; bus.rdreg = 1'b0; bus.clr_overflow = 1'b0;
        bus.dataA = 32'hDEAD_0001; bus.dataB = 32'hBEEF_0001;
        cycle();
        cycle();
        chk_en = 1'b1;
        // Reset release with strobe held high: no push
        reset = 1'b0;
        cycle();
        cycle();
        chk("rst_empty", 64'(bus.fifo_empty), 64'd1);
        chk("rst_used",  64'(bus.used_words), 64'd0);
        chk("rst_ovf",   64'(bus.overflow),   64'd0);
        chk("rst_dataA", 64'(bus.dataA_out),  64'd0);
        idle();
        cycle();

        // Write / read / empty
        wr(32'h0000_0005, 32'h1234_5678, 1'b0);
        chk("wr_op",    64'(bus.opCode),     64'd5);
        chk("wr_dataB", 64'(bus.dataB_out),  64'h1234_5678);
        chk("wr_used",  64'(bus.used_words), 64'd1);
        pop1();
        chk("rd_empty", 64'(bus.fifo_empty), 64'd1);
        chk("rd_dataA", 64'(bus.dataA_out),  64'd0);
        chk("rd_dataB", 64'(bus.dataB_out),  64'd0);

        // Fill and drop
        for (int i = 0; i < DEPTH; i++) wr(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1'b0);
        wr(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("fill_full", 64'(bus.fifo_full),  64'd1);
        chk("fill_used", 64'(bus.used_words), 64'd16);
`ifdef INSTR_FIFO_OVERFLOW_EN
        chk("fill_ovf", 64'(bus.overflow), 64'd1);
        bus.clr_overflow = 1'b1;
        cycle();
        bus.clr_overflow = 1'b0;
        chk("clr_ovf", 64'(bus.overflow), 64'd0);
        bus.clr_overflow = 1'b1;
        wr(32'hEEEE_EEEE, 32'hEEEE_EEEE, 1'b0);
        bus.clr_overflow = 1'b0;
        chk("set_wins", 64'(bus.overflow), 64'd1);
        bus.clr_overflow = 1'b1;
        cycle();
        bus.clr_overflow = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            chk("order_A", 64'(bus.dataA_out), 64'(32'hA000_0000 + 32'(i)));
            chk("order_B", 64'(bus.dataB_out), 64'(32'hB000_0000 + 32'(i)));
            pop1();
        end
        chk("drain_empty", 64'(bus.fifo_empty), 64'd1);
        wr(32'h0000_0003, 32'h0000_0033, 1'b0);
        chk("wrap_op", 64'(bus.opCode), 64'd3);
        pop1();

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) wr(32'hC000_0000 + 32'(i), 32'(i), 1'b0);
        bus.dataA = 32'h0000_0009; bus.dataB = 32'h9999_9999;
        bus.wrreg = 1'b1; bus.rdreg = 1'b1;
        cycle();
        idle();
        chk("fullpp_used", 64'(bus.used_words), 64'd16);
        chk("fullpp_head", 64'(bus.dataA_out),  64'hC000_0001);
        for (int i = 0; i < DEPTH - 1; i++) pop1();
        chk("fullpp_last", 64'(bus.dataB_out), 64'h9999_9999);
        pop1();
        chk("fullpp_empty", 64'(bus.fifo_empty), 64'd1);

        // Empty with simultaneous push and pop
        cycle();
        bus.dataA = 32'h0000_000C; bus.dataB = 32'h0C0C_0C0C;
        bus.wrreg = 1'b1; bus.rdreg = 1'b1;
        cycle();
        idle();
        chk("emptypp_used", 64'(bus.used_words), 64'd1);
        chk("emptypp_head", 64'(bus.dataB_out),  64'h0C0C_0C0C);
        pop1();

        // Reset mid-operation
        for (int i = 0; i < 5; i++) wr(32'(i), 32'(i), 1'b0);
        chk("mid_used5", 64'(bus.used_words), 64'd5);
        do_reset();
        chk("mid_used", 64'(bus.used_words), 64'd0);
        chk("mid_empty", 64'(bus.fifo_empty), 64'd1);

        // Randomized traffic, first write-heavy then balanced
        for (int i = 0; i < 4000; i++) begin
            bus.wrreg = 1'($urandom_range(0, 1));
            bus.dataA = $urandom;
            bus.dataB = $urandom;
            bus.rdreg = (i < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            bus.clr_overflow = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
